// File: rtl/neuron_pkg.sv
// Shared types for the serial-MAC neuron layer: activation encodings,
// sequencer state encoding and a clog2 helper for index widths.
package neuron_pkg;

    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'b00,
        ACT_RELU     = 2'b01,
        ACT_LEAKY    = 2'b10,
        ACT_CLAMP    = 2'b11
    } act_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6,
        ST_DRAIN   = 3'd7
    } seq_state_e;

    // Ceiling log2, never below 1 so a single-row layer still has an index bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        if (result < 1) result = 1;
        return result;
    endfunction

endpackage

// File: rtl/neuron_layer_sequencer.sv
// Runs one fully-connected layer row by row through a shared serial MAC
// neuron, writing each result out and tracking the running argmax.
//
// state    | meaning
// IDLE     | waiting for start; err pulse on an illegal row count
// FETCH    | pm_rd for the current row
// WAIT_RD  | capture weights, bias and mask from parameter memory
// ISSUE    | present operands to the neuron until n_in_ready
// COMPUTE  | wait for the neuron result
// WRITE    | res_we for the row, update argmax, advance or finish
// DONE     | one-cycle done pulse
// DRAIN    | aborted mid-compute; swallow the in-flight result
module neuron_layer_sequencer
    import neuron_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int X_W         = 8,
    parameter int W_W         = 8,
    parameter int B_W         = 32,
    parameter int OUT_W       = 16,
    parameter int MAX_NEURONS = 16,
    parameter int NA_W        = clog2(MAX_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NA_W:0]                 num_neurons,
    input  logic [1:0]                    act_sel,
    input  logic [NUM_INPUTS*X_W-1:0]     x_flat,
    input  logic                          abort,
    output logic                          pm_rd,
    output logic [NA_W-1:0]               pm_addr,
    input  logic [NUM_INPUTS*W_W-1:0]     pm_w_rdata,
    input  logic [B_W-1:0]                pm_b_rdata,
    input  logic [NUM_INPUTS-1:0]         pm_m_rdata,
    output logic                          n_in_valid,
    input  logic                          n_in_ready,
    output logic [B_W-1:0]                n_bias,
    output logic [NUM_INPUTS*X_W-1:0]     n_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]     n_w_flat,
    output logic [NUM_INPUTS-1:0]         n_mask,
    output logic [1:0]                    n_act_sel,
    input  logic                          n_out_valid,
    input  logic signed [OUT_W-1:0]       n_out_data,
    output logic                          res_we,
    output logic [NA_W-1:0]               res_addr,
    output logic [OUT_W-1:0]              res_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [NA_W-1:0]               argmax_idx,
    output logic signed [OUT_W-1:0]       max_val
);

    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [NA_W:0]           MAX_N   = (NA_W+1)'(MAX_NEURONS);

    seq_state_e                  state_q, state_d;
    logic [NA_W-1:0]             row_q, row_d;
    logic [NA_W:0]               num_q, num_d;
    logic [NUM_INPUTS*X_W-1:0]   x_q, x_d;
    logic [1:0]                  act_q, act_d;
    logic [NUM_INPUTS*W_W-1:0]   w_q, w_d;
    logic [B_W-1:0]              b_q, b_d;
    logic [NUM_INPUTS-1:0]       m_q, m_d;
    logic signed [OUT_W-1:0]     res_q, res_d;
    logic signed [OUT_W-1:0]     max_q, max_d;
    logic [NA_W-1:0]             argmax_q, argmax_d;
    logic                        err_q, err_d;
    logic                        last_row;

    assign last_row = ({1'b0, row_q} == (num_q - (NA_W+1)'(1)));

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        num_d    = num_q;
        x_d      = x_q;
        act_d    = act_q;
        w_d      = w_q;
        b_d      = b_q;
        m_d      = m_q;
        res_d    = res_q;
        max_d    = max_q;
        argmax_d = argmax_q;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_neurons == '0 || num_neurons > MAX_N) begin
                        err_d = 1'b1;
                    end else begin
                        x_d      = x_flat;
                        act_d    = act_sel;
                        num_d    = num_neurons;
                        row_d    = '0;
                        max_d    = OUT_MIN;
                        argmax_d = '0;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = abort ? ST_IDLE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    w_d     = pm_w_rdata;
                    b_d     = pm_b_rdata;
                    m_d     = pm_m_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An abort coinciding with acceptance still has a result in flight.
                if (abort) begin
                    state_d = n_in_ready ? ST_DRAIN : ST_IDLE;
                end else if (n_in_ready) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (abort) begin
                    state_d = n_out_valid ? ST_IDLE : ST_DRAIN;
                end else if (n_out_valid) begin
                    res_d   = n_out_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Strict compare keeps the lowest row on ties.
                if (res_q > max_q) begin
                    max_d    = res_q;
                    argmax_d = row_q;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_row) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + NA_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (n_out_valid) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            num_q    <= '0;
            x_q      <= '0;
            act_q    <= '0;
            w_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            res_q    <= '0;
            max_q    <= OUT_MIN;
            argmax_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            num_q    <= num_d;
            x_q      <= x_d;
            act_q    <= act_d;
            w_q      <= w_d;
            b_q      <= b_d;
            m_q      <= m_d;
            res_q    <= res_d;
            max_q    <= max_d;
            argmax_q <= argmax_d;
            err_q    <= err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign pm_rd      = (state_q == ST_FETCH);
    assign pm_addr    = row_q;
    assign n_in_valid = (state_q == ST_ISSUE);
    assign n_bias     = b_q;
    assign n_x_flat   = x_q;
    assign n_w_flat   = w_q;
    assign n_mask     = m_q;
    assign n_act_sel  = act_q;
    assign res_we     = (state_q == ST_WRITE);
    assign res_addr   = row_q;
    assign res_data   = res_q;
    assign argmax_idx = argmax_q;
    assign max_val    = max_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: behavioural parameter memory and neuron,
// with expected results computed directly from the layer's arithmetic.
module tb_neuron_layer_sequencer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [4:0]         num_neurons;
    logic [1:0]         act_sel;
    logic [63:0]        x_flat;
    logic               abort;
    logic               pm_rd;
    logic [3:0]         pm_addr;
    logic [63:0]        pm_w_rdata;
    logic [31:0]        pm_b_rdata;
    logic [7:0]         pm_m_rdata;
    logic               n_in_valid;
    logic               n_in_ready;
    logic [31:0]        n_bias;
    logic [63:0]        n_x_flat;
    logic [63:0]        n_w_flat;
    logic [7:0]         n_mask;
    logic [1:0]         n_act_sel;
    logic               n_out_valid;
    logic signed [15:0] n_out_data;
    logic               res_we;
    logic [3:0]         res_addr;
    logic [15:0]        res_data;
    logic               busy;
    logic               done;
    logic               err;
    logic [3:0]         argmax_idx;
    logic signed [15:0] max_val;

    neuron_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_neurons(num_neurons),
        .act_sel(act_sel), .x_flat(x_flat), .abort(abort),
        .pm_rd(pm_rd), .pm_addr(pm_addr), .pm_w_rdata(pm_w_rdata),
        .pm_b_rdata(pm_b_rdata), .pm_m_rdata(pm_m_rdata),
        .n_in_valid(n_in_valid), .n_in_ready(n_in_ready), .n_bias(n_bias),
        .n_x_flat(n_x_flat), .n_w_flat(n_w_flat), .n_mask(n_mask),
        .n_act_sel(n_act_sel), .n_out_valid(n_out_valid), .n_out_data(n_out_data),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .err(err),
        .argmax_idx(argmax_idx), .max_val(max_val)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem_w [16];
    logic [31:0] mem_b [16];
    logic [7:0]  mem_m [16];

    logic [3:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int pm_rd_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    int stall_left  = 0;
    int stall_max   = 0;
    int stall_total = 0;

    // Reference neuron: masked signed dot product plus bias, saturate, activate.
    function automatic int neuron_fn(logic [63:0] x, logic [63:0] w, logic [31:0] b,
                                     logic [7:0] m, logic [1:0] act);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < 8; i++)
            if (m[i]) acc += longint'($signed(x[i*8 +: 8])) * longint'($signed(w[i*8 +: 8]));
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        case (act)
            2'b01:   if (acc < 0) acc = 0;
            2'b10:   if (acc < 0) acc = acc >>> 3;
            2'b11:   begin if (acc > 127) acc = 127; if (acc < -128) acc = -128; end
            default: ;
        endcase
        return int'(acc);
    endfunction

    // Parameter memory: data valid only in the cycle after pm_rd, junk otherwise.
    initial begin : pmem
        logic       rd;
        logic [3:0] a;
        pm_w_rdata = '0; pm_b_rdata = '0; pm_m_rdata = '0;
        forever begin
            @(negedge clk);
            rd = pm_rd;
            a  = pm_addr;
            @(posedge clk);
            #1;
            if (rd) begin
                pm_w_rdata = mem_w[a];
                pm_b_rdata = mem_b[a];
                pm_m_rdata = mem_m[a];
            end else begin
                pm_w_rdata = {$urandom, $urandom};
                pm_b_rdata = $urandom;
                pm_m_rdata = 8'($urandom);
            end
        end
    end

    // Neuron: optional ready stalls, result pulse 9 cycles after acceptance.
    initial begin : nmodel
        int cnt;
        logic signed [15:0] pend;
        cnt = 0; pend = '0;
        n_out_valid = 1'b0; n_out_data = '0; n_in_ready = 1'b1;
        forever begin
            @(negedge clk);
            n_out_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    n_out_valid = 1'b1;
                    n_out_data  = pend;
                end
            end
            if (n_in_valid && stall_left > 0) begin
                n_in_ready = 1'b0;
                stall_left--;
                stall_total++;
            end else begin
                n_in_ready = 1'b1;
                if (n_in_valid) begin
                    pend       = 16'(neuron_fn(n_x_flat, n_w_flat, n_bias, n_mask, n_act_sel));
                    cnt        = 9;
                    stall_left = $urandom_range(0, stall_max);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (res_we) begin
                wr_addr_q.push_back(res_addr);
                wr_data_q.push_back(res_data);
            end
            if (pm_rd) pm_rd_cnt++;
            if (done)  done_cnt++;
            if (err)   err_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog expired");
    end

    // Stimulus only: runs one layer, reporting the done cycle and the first idle cycle.
    task automatic run_layer(input int k, input logic [1:0] act, input logic [63:0] x,
                             input int abort_at, input bit hold_start,
                             output int done_at, output int end_at, output bit timeout);
        @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete();
        pm_rd_cnt = 0; done_cnt = 0; stall_total = 0;
        abort = 1'b0;
        num_neurons = 5'(k); act_sel = act; x_flat = x; start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        num_neurons = 5'($urandom); act_sel = 2'($urandom); x_flat = {$urandom, $urandom};
        done_at = -1; end_at = -1; timeout = 1'b0;
        for (int c = 1; c < 3000; c++) begin
            abort = (c == abort_at);
            if (done && done_at < 0) begin
                done_at = c;
                start   = 1'b0;
            end
            if (!busy) begin
                end_at = c;
                break;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        if (end_at < 0) begin
            timeout = 1'b1;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_neurons = '0; act_sel = '0; x_flat = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, pm_rd, n_in_valid, res_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 000000", {busy, done, err, pm_rd, n_in_valid, res_we});
        end
        n_checks++;
        if (max_val !== 16'sh8000) begin
            n_fail++; $display("FAIL reset_max_val: got %0d expected -32768", max_val);
        end
        n_checks++;
        if ({argmax_idx, pm_addr, res_addr, res_data} !== 28'h0) begin
            n_fail++; $display("FAIL reset_indices: got %h expected 0", {argmax_idx, pm_addr, res_addr, res_data});
        end
        n_checks++;
        if ({n_x_flat, n_w_flat, n_bias, n_mask, n_act_sel} !== 170'h0) begin
            n_fail++; $display("FAIL reset_operands: got nonzero expected 0");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int done_at, end_at, got;
        bit to;
        int exp_v [2];
        for (int r = 0; r < 16; r++) begin mem_w[r] = '0; mem_b[r] = '0; mem_m[r] = 8'hFF; end
        mem_w[0] = {8{8'h10}};
        mem_w[1] = {8{8'hF0}};
        exp_v[0] = 2048; exp_v[1] = -2048;
        stall_max = 0; stall_left = 0;
        run_layer(2, 2'b00, {8{8'h10}}, 0, 1'b0, done_at, end_at, to);
        n_checks++;
        if (done_at !== 27) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 27", done_at); end
        n_checks++;
        if (wr_addr_q.size() !== 2) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 2", wr_addr_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < wr_data_q.size()) ? int'($signed(wr_data_q[i])) : 99999;
            n_checks++;
            if (got !== exp_v[i] || (i < wr_addr_q.size() && wr_addr_q[i] !== 4'(i))) begin
                n_fail++; $display("FAIL basic_result row%0d: got %0d expected %0d", i, got, exp_v[i]);
            end
        end
        n_checks++;
        if (argmax_idx !== 4'd0 || max_val !== 16'sd2048) begin
            n_fail++; $display("FAIL basic_argmax: got idx %0d val %0d expected idx 0 val 2048", argmax_idx, max_val);
        end
        n_checks++;
        if (pm_rd_cnt !== 2 || done_cnt !== 1) begin
            n_fail++; $display("FAIL basic_strobes: got pm_rd %0d done %0d expected 2 1", pm_rd_cnt, done_cnt);
        end
    endtask

    task automatic test_err();
        logic [63:0] x_before;
        int vals [2];
        vals[0] = 0; vals[1] = 17;
        x_before = {8{8'h10}};
        pm_rd_cnt = 0; err_cnt = 0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            num_neurons = 5'(vals[t]); x_flat = {$urandom, $urandom}; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL err_pulse n=%0d: got err %b busy %b expected 1 0", vals[t], err, busy);
            end
            @(negedge clk);
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL err_one_cycle n=%0d: got err %b busy %b expected 0 0", vals[t], err, busy);
            end
        end
        @(negedge clk);
        n_checks++;
        if (pm_rd_cnt !== 0 || err_cnt !== 2 || n_x_flat !== x_before) begin
            n_fail++; $display("FAIL err_side_effects: got pm_rd %0d err %0d x %h expected 0 2 %h", pm_rd_cnt, err_cnt, n_x_flat, x_before);
        end
    endtask

    task automatic test_stall();
        int done_at, end_at, exp_r;
        bit to;
        logic [63:0] x;
        x = {$urandom, $urandom};
        mem_w[0] = {$urandom, $urandom}; mem_b[0] = $urandom_range(0, 4000) - 2000; mem_m[0] = 8'($urandom);
        exp_r = neuron_fn(x, mem_w[0], mem_b[0], mem_m[0], 2'b01);
        stall_max = 0; stall_left = 5;
        fork
            run_layer(1, 2'b01, x, 0, 1'b0, done_at, end_at, to);
            begin
                int w;
                w = 0;
                while (!n_in_valid && w < 40) begin @(negedge clk); w++; end
                for (int s = 0; s < 6; s++) begin
                    n_checks++;
                    if (n_in_valid !== 1'b1 || n_w_flat !== mem_w[0] || n_bias !== mem_b[0] ||
                        n_mask !== mem_m[0] || n_x_flat !== x || n_act_sel !== 2'b01) begin
                        n_fail++; $display("FAIL stall_operands cycle%0d: got valid %b w %h b %h expected 1 %h %h",
                                           s, n_in_valid, n_w_flat, n_bias, mem_w[0], mem_b[0]);
                    end
                    @(negedge clk);
                end
            end
        join
        n_checks++;
        if (done_at !== 19) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 19", done_at); end
        n_checks++;
        if (wr_data_q.size() !== 1 || int'($signed(wr_data_q[0])) !== exp_r) begin
            n_fail++; $display("FAIL stall_result: got %0d writes expected 1 of value %0d", wr_data_q.size(), exp_r);
        end
    endtask

    task automatic test_abort();
        int done_at, end_at;
        bit to;
        int ab_at [4];
        int exp_end [4], exp_wr [4], exp_rd [4];
        ab_at[0] = 19; exp_end[0] = 26; exp_wr[0] = 1; exp_rd[0] = 2;
        ab_at[1] = 25; exp_end[1] = 26; exp_wr[1] = 1; exp_rd[1] = 2;
        ab_at[2] = 1;  exp_end[2] = 2;  exp_wr[2] = 0; exp_rd[2] = 1;
        ab_at[3] = 13; exp_end[3] = 14; exp_wr[3] = 1; exp_rd[3] = 1;
        for (int r = 0; r < 3; r++) begin
            mem_w[r] = {$urandom, $urandom}; mem_b[r] = $urandom; mem_m[r] = 8'($urandom);
        end
        stall_max = 0; stall_left = 0;
        for (int t = 0; t < 4; t++) begin
            run_layer(3, 2'b00, {$urandom, $urandom}, ab_at[t], 1'b0, done_at, end_at, to);
            n_checks++;
            if (end_at !== exp_end[t] || done_at !== -1) begin
                n_fail++; $display("FAIL abort_at%0d_timing: got idle %0d done %0d expected idle %0d no done",
                                   ab_at[t], end_at, done_at, exp_end[t]);
            end
            n_checks++;
            if (wr_addr_q.size() !== exp_wr[t] || pm_rd_cnt !== exp_rd[t] || done_cnt !== 0) begin
                n_fail++; $display("FAIL abort_at%0d_strobes: got writes %0d pm_rd %0d done %0d expected %0d %0d 0",
                                   ab_at[t], wr_addr_q.size(), pm_rd_cnt, done_cnt, exp_wr[t], exp_rd[t]);
            end
        end
    endtask

    task automatic test_ties_and_hold();
        int done_at, end_at, got;
        bit to;
        int exp_v [3];
        exp_v[0] = 100; exp_v[1] = 100; exp_v[2] = 50;
        for (int r = 0; r < 3; r++) begin mem_w[r] = '0; mem_m[r] = 8'hFF; mem_b[r] = 32'(exp_v[r]); end
        stall_max = 0; stall_left = 0;
        run_layer(3, 2'b00, {$urandom, $urandom}, 0, 1'b1, done_at, end_at, to);
        for (int i = 0; i < 3; i++) begin
            got = (i < wr_data_q.size()) ? int'($signed(wr_data_q[i])) : 99999;
            n_checks++;
            if (got !== exp_v[i]) begin n_fail++; $display("FAIL ties_result row%0d: got %0d expected %0d", i, got, exp_v[i]); end
        end
        n_checks++;
        if (argmax_idx !== 4'd0 || max_val !== 16'sd100) begin
            n_fail++; $display("FAIL ties_argmax: got idx %0d val %0d expected 0 100", argmax_idx, max_val);
        end
        n_checks++;
        if (done_at !== 40 || end_at !== 41 || pm_rd_cnt !== 3 || done_cnt !== 1) begin
            n_fail++; $display("FAIL hold_start_no_restart: got done %0d idle %0d pm_rd %0d dones %0d expected 40 41 3 1",
                               done_at, end_at, pm_rd_cnt, done_cnt);
        end
        mem_b[0] = 32'd7;
        run_layer(1, 2'b00, '0, 0, 1'b0, done_at, end_at, to);
        n_checks++;
        if (done_at !== 14 || wr_data_q.size() !== 1 || argmax_idx !== 4'd0 || max_val !== 16'sd7) begin
            n_fail++; $display("FAIL relaunch: got done %0d writes %0d max %0d expected 14 1 7", done_at, wr_data_q.size(), max_val);
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 16; r++) begin mem_w[r] = '0; mem_m[r] = 8'hFF; mem_b[r] = 32'd500; end
        stall_max = 0; stall_left = 0;
        @(negedge clk);
        num_neurons = 5'd4; act_sel = 2'b00; x_flat = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || max_val !== 16'sh8000 || pm_addr !== 4'd0 || n_act_sel !== 2'b00) begin
            n_fail++; $display("FAIL async_reset: got busy %b max %0d row %0d expected 0 -32768 0", busy, max_val, pm_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete();
        repeat (14) @(negedge clk);
        n_checks++;
        if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stray_result_ignored: got writes %0d busy %b expected 0 0", wr_addr_q.size(), busy);
        end
    endtask

    task automatic test_random();
        int done_at, end_at, k, got, best, best_i, ga;
        bit to;
        logic [1:0]  act;
        logic [63:0] x;
        int exp_v [16];
        stall_max = 2;
        for (int l = 0; l < 8; l++) begin
            k   = $urandom_range(1, 16);
            act = 2'($urandom);
            x   = {$urandom, $urandom};
            for (int r = 0; r < 16; r++) begin
                mem_w[r] = {$urandom, $urandom};
                mem_b[r] = (l % 2 == 0) ? 32'($urandom_range(0, 60000)) - 32'd30000 : $urandom;
                mem_m[r] = 8'($urandom);
            end
            best = -32768; best_i = 0;
            for (int r = 0; r < k; r++) begin
                exp_v[r] = neuron_fn(x, mem_w[r], mem_b[r], mem_m[r], act);
                if (exp_v[r] > best) begin best = exp_v[r]; best_i = r; end
            end
            stall_left = $urandom_range(0, 2);
            run_layer(k, act, x, 0, 1'b0, done_at, end_at, to);
            n_checks++;
            if (done_at !== k * 13 + stall_total + 1 || end_at !== done_at + 1) begin
                n_fail++; $display("FAIL rand%0d_timing: got done %0d expected %0d (k=%0d)", l, done_at, k * 13 + stall_total + 1, k);
            end
            n_checks++;
            if (wr_addr_q.size() !== k || pm_rd_cnt !== k || done_cnt !== 1) begin
                n_fail++; $display("FAIL rand%0d_counts: got writes %0d pm_rd %0d done %0d expected %0d %0d 1",
                                   l, wr_addr_q.size(), pm_rd_cnt, done_cnt, k, k);
            end
            for (int i = 0; i < k; i++) begin
                got = (i < wr_data_q.size()) ? int'($signed(wr_data_q[i])) : 99999;
                ga  = (i < wr_addr_q.size()) ? int'(wr_addr_q[i]) : -1;
                n_checks++;
                if (got !== exp_v[i] || ga !== i) begin
                    n_fail++; $display("FAIL rand%0d_row%0d: got addr %0d data %0d expected addr %0d data %0d",
                                       l, i, ga, got, i, exp_v[i]);
                end
            end
            n_checks++;
            if (int'(argmax_idx) !== best_i || int'(max_val) !== best) begin
                n_fail++; $display("FAIL rand%0d_argmax: got idx %0d val %0d expected %0d %0d", l, argmax_idx, max_val, best_i, best);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_stall();
        test_abort();
        test_ties_and_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
